display_scheduler: RTL and testbench

Time-shares the signed 4-digit seven-segment display driver among three 9-bit two's-complement sources: operand A, operand B and the arithmetic result. The block sits directly upstream of the display driver's `resultado` input. It shows each freshly updated source for a programmable dwell time, in round-robin order. When no source is pending it keeps the last shown value on screen.

---
 rtl/display_scheduler.sv | 147 ++++++++++++++
 tb/tb_display_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Time-shares the signed display driver among operand A, operand B and the result.
// Freshly updated sources are shown round-robin, each for DWELL_CYCLES clocks.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   S_IDLE | nothing shown yet (sel = 3, resultado = 0); waits for a pending source
//   S_SHOW | a source is on screen; the dwell counter runs, and a switch is
//          | allowed at terminal count
module display_scheduler #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] a_val,
    input  logic       a_upd,
    input  logic [8:0] b_val,
    input  logic       b_upd,
    input  logic [8:0] r_val,
    input  logic       r_upd,
    input  logic       hold,
    output logic [8:0] resultado,
    output logic [1:0] sel,
    output logic [2:0] pend
);

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] TC = CW'(DWELL_CYCLES - 1);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    res_d;
    logic [1:0]    sel_d;
    logic [2:0]    pend_d;
    logic [2:0]    pend_set;
    logic [2:0]    upd;
    logic [8:0]    in_val   [3];
    logic [8:0]    shadow_q [3];
    logic [8:0]    shadow_d [3];
    logic          grant;
    logic [1:0]    gidx;
    logic          self_upd;
    logic [8:0]    self_val;

    assign upd       = {r_upd, b_upd, a_upd};
    assign in_val[0] = a_val;
    assign in_val[1] = b_val;
    assign in_val[2] = r_val;

    function automatic logic [1:0] lowest(input logic [2:0] p);
        lowest = 2'd3;
        for (int i = 2; i >= 0; i--) begin
            if (p[i]) lowest = 2'(i);
        end
    endfunction

    // Scan downwards so the closest index after s (wrapping) wins.
    function automatic logic [1:0] next_after(input logic [2:0] p, input logic [1:0] s);
        int idx;
        next_after = 2'd3;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(s) + k) % 3;
            if (p[idx]) next_after = 2'(idx);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = resultado;
        sel_d    = sel;
        pend_set = upd;
        grant    = 1'b0;
        gidx     = 2'd3;
        self_upd = 1'b0;
        self_val = '0;

        for (int i = 0; i < 3; i++) begin
            shadow_d[i] = upd[i] ? in_val[i] : shadow_q[i];
            if (sel == 2'(i) && upd[i]) begin
                self_upd = 1'b1;
                self_val = in_val[i];
            end
        end

        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (|pend) begin
                        grant   = 1'b1;
                        gidx    = lowest(pend);
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    // An update of the shown source refreshes in place instead of queuing.
                    if (self_upd) begin
                        res_d = self_val;
                        cnt_d = '0;
                        for (int i = 0; i < 3; i++) begin
                            if (sel == 2'(i)) pend_set[i] = 1'b0;
                        end
                    end else if (cnt_q == TC) begin
                        cnt_d = '0;
                        if (|pend) begin
                            grant = 1'b1;
                            gidx  = next_after(pend, sel);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end

        pend_d = pend | pend_set;
        for (int i = 0; i < 3; i++) begin
            if (grant && gidx == 2'(i)) begin
                res_d     = shadow_d[i];
                sel_d     = gidx;
                cnt_d     = '0;
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            resultado <= '0;
            sel       <= 2'd3;
            pend      <= '0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            resultado <= res_d;
            sel       <= sel_d;
            pend      <= pend_d;
            for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a per-cycle reference model of the
// scheduling rules plus hand-computed spot checks.
module tb_display_scheduler;

    localparam int DW = 4;

    logic       clk;
    logic       rst_n;
    logic [8:0] a_val, b_val, r_val;
    logic       a_upd, b_upd, r_upd;
    logic       hold;
    logic [8:0] resultado;
    logic [1:0] sel;
    logic [2:0] pend;

    int n_total = 0;
    int n_pass  = 0;

    display_scheduler #(.DWELL_CYCLES(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_val    (a_val),
        .a_upd    (a_upd),
        .b_val    (b_val),
        .b_upd    (b_upd),
        .r_val    (r_val),
        .r_upd    (r_upd),
        .hold     (hold),
        .resultado(resultado),
        .sel      (sel),
        .pend     (pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: what is shown, what is waiting, and how many cycles of
    // screen time the current value still has before a switch is allowed.
    bit         m_valid = 0;
    int         m_sel;
    int         m_left;
    logic [8:0] m_res;
    logic [2:0] m_pend;
    logic [8:0] m_shadow [3];

    always @(posedge clk) begin : model
        logic [2:0] u;
        logic [8:0] v [3];
        logic [2:0] old;
        int         g;
        u    = {r_upd, b_upd, a_upd};
        v[0] = a_val;
        v[1] = b_val;
        v[2] = r_val;
        if (!rst_n) begin
            m_valid = 1;
            m_sel   = 3;
            m_res   = '0;
            m_pend  = '0;
            m_left  = 0;
            for (int i = 0; i < 3; i++) m_shadow[i] = '0;
        end else begin
            old = m_pend;
            g   = -1;
            for (int i = 0; i < 3; i++) if (u[i]) m_shadow[i] = v[i];
            m_pend = old | u;
            if (!hold) begin
                if (m_sel == 3) begin
                    for (int i = 2; i >= 0; i--) if (old[i]) g = i;
                end else if (u[m_sel]) begin
                    m_res         = v[m_sel];
                    m_left        = DW;
                    m_pend[m_sel] = old[m_sel];
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_left = DW;
                        for (int k = 3; k >= 1; k--) if (old[(m_sel + k) % 3]) g = (m_sel + k) % 3;
                    end
                end
                if (g >= 0) begin
                    m_sel     = g;
                    m_res     = m_shadow[g];
                    m_pend[g] = 1'b0;
                    m_left    = DW;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_resultado", 16'(resultado), 16'(m_res));
            check("model_sel", 16'(sel), 16'(m_sel));
            check("model_pend", 16'(pend), 16'(m_pend));
        end
    end

    initial begin
        // 1: reset with strobes active
        rst_n = 0; hold = 0;
        a_upd = 1; b_upd = 1; r_upd = 1;
        a_val = 9'd1; b_val = 9'd2; r_val = 9'd3;
        step(3);
        check("rst_sel", 16'(sel), 16'd3);
        check("rst_res", 16'(resultado), 16'd0);
        check("rst_pend", 16'(pend), 16'd0);
        rst_n = 1; a_upd = 0; b_upd = 0; r_upd = 0;
        step(1);
        check("post_rst_sel", 16'(sel), 16'd3);
        check("post_rst_pend", 16'(pend), 16'd0);

        // 2: IDLE grant of R = -2
        r_val = 9'h1FE; r_upd = 1;
        step(1); r_upd = 0;
        check("idle_pend", 16'(pend), 16'b100);
        check("idle_sel_wait", 16'(sel), 16'd3);
        step(1);
        check("idle_sel", 16'(sel), 16'd2);
        check("idle_res", 16'(resultado), 16'h1FE);
        check("idle_pend_clr", 16'(pend), 16'd0);
        step(10);
        check("idle_persist", 16'(resultado), 16'h1FE);

        // 3: round-robin of simultaneous strobes
        rst_n = 0; step(1); rst_n = 1;
        a_val = 9'd2; b_val = 9'd128; r_val = 9'h181;
        a_upd = 1; b_upd = 1; r_upd = 1;
        step(1); a_upd = 0; b_upd = 0; r_upd = 0;
        check("rr_pend_all", 16'(pend), 16'b111);
        step(1);
        check("rr_a_sel", 16'(sel), 16'd0);
        check("rr_a_res", 16'(resultado), 16'd2);
        check("rr_a_pend", 16'(pend), 16'b110);
        step(3);
        check("rr_a_dwell", 16'(sel), 16'd0);
        step(1);
        check("rr_b_sel", 16'(sel), 16'd1);
        check("rr_b_res", 16'(resultado), 16'h080);
        step(3);
        check("rr_b_dwell", 16'(sel), 16'd1);
        step(1);
        check("rr_r_sel", 16'(sel), 16'd2);
        check("rr_r_res", 16'(resultado), 16'h181);
        check("rr_r_pend", 16'(pend), 16'd0);
        step(8);
        check("rr_r_persist", 16'(sel), 16'd2);

        // 4: self-update restarts dwell, then grant-edge collision on B
        rst_n = 0; step(1); rst_n = 1;
        a_val = 9'd5; a_upd = 1;
        step(1); a_upd = 0;
        step(1);
        check("self_a_sel", 16'(sel), 16'd0);
        step(1);
        a_val = 9'd255; a_upd = 1;
        step(1); a_upd = 0;
        check("self_res", 16'(resultado), 16'h0FF);
        check("self_pend", 16'(pend), 16'd0);
        b_val = 9'd10; b_upd = 1;
        step(1); b_upd = 0;
        check("coll_b_pend", 16'(pend), 16'b010);
        step(2);
        check("self_restart", 16'(sel), 16'd0);
        b_val = 9'h1FB; b_upd = 1;
        step(1); b_upd = 0;
        check("coll_sel", 16'(sel), 16'd1);
        check("coll_res", 16'(resultado), 16'h1FB);
        check("coll_pend", 16'(pend), 16'd0);

        // 5: hold mid-dwell while B is strobed with -255
        step(2);
        hold = 1; b_val = 9'h101; b_upd = 1;
        step(1); b_upd = 0;
        check("hold_pend", 16'(pend), 16'b010);
        step(9);
        check("hold_res", 16'(resultado), 16'h1FB);
        check("hold_sel", 16'(sel), 16'd1);
        hold = 0;
        step(1);
        check("hold_resume", 16'(resultado), 16'h1FB);
        step(1);
        check("hold_new_res", 16'(resultado), 16'h101);
        check("hold_new_pend", 16'(pend), 16'd0);

        // 6: reset mid-dwell with A pending, then hold blocks the IDLE grant
        a_val = 9'd7; a_upd = 1;
        step(1); a_upd = 0;
        check("mid_pend", 16'(pend), 16'b001);
        step(1);
        rst_n = 0;
        step(1); rst_n = 1;
        check("mid_rst_sel", 16'(sel), 16'd3);
        check("mid_rst_res", 16'(resultado), 16'd0);
        check("mid_rst_pend", 16'(pend), 16'd0);
        step(1);
        hold = 1; a_val = 9'h0AA; a_upd = 1;
        step(1); a_upd = 0;
        check("idle_hold_pend", 16'(pend), 16'b001);
        step(2);
        check("idle_hold_sel", 16'(sel), 16'd3);
        hold = 0;
        step(1);
        check("idle_rel_sel", 16'(sel), 16'd0);
        check("idle_rel_res", 16'(resultado), 16'h0AA);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
